// File: rtl/lcd_frame_sched_if.sv
// Scheduler-side bundle: refresh request, frame-source fetch handshake, LCD write port and status.
// master = scheduler, slave = environment (frame source, LCD, host).
interface lcd_frame_sched_if;
  logic       start;
  logic       src_en;
  logic [7:0] src_data;
  logic       src_valid;
  logic       lcd_busy;
  logic       lcd_wr;
  logic       lcd_rs;
  logic [7:0] lcd_data;
  logic       busy;
  logic       frame_done;
  logic       err;

  modport master (
    input  start, src_data, src_valid, lcd_busy,
    output src_en, lcd_wr, lcd_rs, lcd_data, busy, frame_done, err
  );

  modport slave (
    output start, src_data, src_valid, lcd_busy,
    input  src_en, lcd_wr, lcd_rs, lcd_data, busy, frame_done, err
  );
endinterface

// File: rtl/lcd_frame_sched.sv
// Streams an 8-page x 64-column frame to the LCD: per page two address commands, then fetch/write per byte.
// Registered outputs; first strobe 2 cycles after start, 3 cycles per byte; lcd_busy stalls any write in place.
module lcd_frame_sched #(
  parameter logic [7:0] CMD_PAGE = 8'hB8,
  parameter logic [7:0] CMD_COL  = 8'h40,
  parameter logic [7:0] WAIT_MAX = 8'd16
) (
  input  logic              clk,
  input  logic              rst,
  lcd_frame_sched_if.master bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SET_PAGE  = 3'd1;
  localparam logic [2:0] S_SET_COL   = 3'd2;
  localparam logic [2:0] S_FETCH     = 3'd3;
  localparam logic [2:0] S_WAIT_DATA = 3'd4;
  localparam logic [2:0] S_WRITE     = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  logic [2:0] state_q, state_d;
  logic [2:0] page_q, page_d;
  logic [5:0] col_q, col_d;
  logic       pending_q, pending_d;
  logic [7:0] tmo_q, tmo_d;
  logic [7:0] byte_q, byte_d;
  logic       err_q, err_d;
  logic       src_en_q, src_en_d;
  logic       lcd_wr_q, lcd_wr_d;
  logic       lcd_rs_q, lcd_rs_d;
  logic [7:0] lcd_data_q, lcd_data_d;
  logic       busy_q, busy_d;
  logic       frame_done_q, frame_done_d;
  logic       tmo_hit;

  // Abort once this WAIT_DATA cycle would be the WAIT_MAX-th without data.
  assign tmo_hit = ({1'b0, tmo_q} + 9'd1) >= {1'b0, WAIT_MAX};

  always_comb begin
    state_d    = state_q;
    page_d     = page_q;
    col_d      = col_q;
    pending_d  = pending_q;
    tmo_d      = tmo_q;
    byte_d     = byte_q;
    err_d      = err_q;
    lcd_wr_d   = 1'b0;
    lcd_rs_d   = 1'b0;
    lcd_data_d = 8'h00;

    if (state_q != S_IDLE && bus.start) begin
      pending_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        page_d = 3'd0;
        col_d  = 6'd0;
        if (bus.start) begin
          err_d   = 1'b0;
          state_d = S_SET_PAGE;
        end
      end
      S_SET_PAGE: begin
        if (!bus.lcd_busy) begin
          lcd_wr_d   = 1'b1;
          lcd_data_d = CMD_PAGE | {5'd0, page_q};
          state_d    = S_SET_COL;
        end
      end
      S_SET_COL: begin
        if (!bus.lcd_busy) begin
          lcd_wr_d   = 1'b1;
          lcd_data_d = CMD_COL;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        tmo_d   = 8'd0;
        state_d = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        if (bus.src_valid) begin
          byte_d  = bus.src_data;
          state_d = S_WRITE;
        end else if (tmo_hit) begin
          err_d     = 1'b1;
          pending_d = 1'b0;
          state_d   = S_IDLE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_WRITE: begin
        if (!bus.lcd_busy) begin
          lcd_wr_d   = 1'b1;
          lcd_rs_d   = 1'b1;
          lcd_data_d = byte_q;
          if (col_q != 6'd63) begin
            col_d   = col_q + 6'd1;
            state_d = S_FETCH;
          end else if (page_q != 3'd7) begin
            col_d   = 6'd0;
            page_d  = page_q + 3'd1;
            state_d = S_SET_PAGE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        // Counters are rewound here so a back-to-back frame starts at page 0.
        page_d = 3'd0;
        col_d  = 6'd0;
        if (pending_q || bus.start) begin
          pending_d = 1'b0;
          state_d   = S_SET_PAGE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs track the next state so they line up with the state they describe.
    src_en_d     = (state_d == S_FETCH);
    busy_d       = (state_d != S_IDLE);
    frame_done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      page_q       <= 3'd0;
      col_q        <= 6'd0;
      pending_q    <= 1'b0;
      tmo_q        <= 8'd0;
      byte_q       <= 8'h00;
      err_q        <= 1'b0;
      src_en_q     <= 1'b0;
      lcd_wr_q     <= 1'b0;
      lcd_rs_q     <= 1'b0;
      lcd_data_q   <= 8'h00;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      page_q       <= page_d;
      col_q        <= col_d;
      pending_q    <= pending_d;
      tmo_q        <= tmo_d;
      byte_q       <= byte_d;
      err_q        <= err_d;
      src_en_q     <= src_en_d;
      lcd_wr_q     <= lcd_wr_d;
      lcd_rs_q     <= lcd_rs_d;
      lcd_data_q   <= lcd_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.src_en     = src_en_q;
  assign bus.lcd_wr     = lcd_wr_q;
  assign bus.lcd_rs     = lcd_rs_q;
  assign bus.lcd_data   = lcd_data_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_lcd_frame_sched.sv
// Bench for lcd_frame_sched: random source latency / LCD busy against a positional frame model
// (strobe k of a frame is page k/66; slot 0/1 are commands, the rest are the source bytes in order).
module tb_lcd_frame_sched;
  localparam int WAIT_MAX = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lcd_frame_sched_if bus ();

  lcd_frame_sched #(
    .CMD_PAGE (8'hB8),
    .CMD_COL  (8'h40),
    .WAIT_MAX (8'(WAIT_MAX))
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic       start = 1'b0;
  logic       lcd_busy = 1'b0;
  logic       resp_valid = 1'b0;
  logic [7:0] resp_data = 8'h00;
  logic       stray_valid = 1'b0;
  logic [7:0] stray_data = 8'h00;

  assign bus.start     = start;
  assign bus.lcd_busy  = lcd_busy;
  assign bus.src_valid = resp_valid | stray_valid;
  assign bus.src_data  = stray_valid ? stray_data : resp_data;

  int n_checks = 0;
  int n_fail = 0;
  int k = 0;
  int total = 0;
  int done_cnt = 0;
  int req_n = 0;
  int drop_n = -1;
  int busy_hold = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  int drop_cyc = 0;
  bit active = 0;
  bit pend = 0;
  bit after_done = 0;
  bit fast = 0;
  bit bp_mode = 0;
  bit busy_rand = 0;
  logic busy_at_edge = 1'b0;
  logic [7:0] exp_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    busy_at_edge <= lcd_busy;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame source: answers each src_en after 1..4 cycles with a random byte (or never, for one chosen request).
  initial begin : responder
    int lat;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (bus.src_en && !rst) begin
        req_n++;
        if (req_n == drop_n) begin
          drop_cyc = cyc;
          continue;
        end
        lat = fast ? 1 : int'($urandom_range(1, 4));
        b = 8'($urandom);
        repeat (lat) @(posedge clk);
        #1;
        resp_valid = 1'b1;
        resp_data  = b;
        exp_q.push_back(b);
        @(posedge clk);
        #1;
        resp_valid = 1'b0;
      end
    end
  end

  // LCD busy: random, or a 10-cycle hold right after the page-0 command and after byte col 16 of page 2.
  initial begin : busy_drv
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode && bus.lcd_wr && !bus.lcd_rs && bus.lcd_data == 8'hB8) busy_hold = 10;
      if (bp_mode && bus.lcd_wr && k == 2 * 66 + 2 + 16) busy_hold = 10;
      if (busy_hold > 0) begin
        lcd_busy = 1'b1;
        busy_hold--;
      end else if (busy_rand) begin
        lcd_busy = ($urandom_range(0, 3) == 0);
      end else begin
        lcd_busy = 1'b0;
      end
    end
  end

  initial begin : monitor
    int j;
    int pg;
    logic e_rs;
    logic [7:0] e_dat;
    forever begin
      @(negedge clk);
      if (after_done) begin
        check("busy_after_done", bus.busy, active);
        after_done = 0;
      end else if (!active) begin
        check("idle_busy", bus.busy, 1'b0);
        check("idle_no_strobe", bus.lcd_wr, 1'b0);
      end
      if (bus.lcd_wr) begin
        check("wr_while_lcd_busy", busy_at_edge, 1'b0);
        check("frame_overrun", k < 528, 1'b1);
        j  = k % 66;
        pg = k / 66;
        if (j == 0) begin
          e_rs  = 1'b0;
          e_dat = 8'hB8 + 8'(pg);
        end else if (j == 1) begin
          e_rs  = 1'b0;
          e_dat = 8'h40;
        end else begin
          e_rs  = 1'b1;
          e_dat = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        end
        check("wr_rs", bus.lcd_rs, e_rs);
        check("wr_data", bus.lcd_data, e_dat);
        if (fast && j >= 3) check("byte_period", cyc - last_wr_cyc, 3);
        if (bp_mode && (k == 1 || k == 2 * 66 + 2 + 17)) check("bp_release_gap", cyc - last_wr_cyc, 11);
        last_wr_cyc = cyc;
        k++;
        total++;
      end
      if (bus.frame_done) begin
        check("frame_len", k, 528);
        check("busy_at_done", bus.busy, 1'b1);
        done_cnt++;
        k = 0;
        if (pend) pend = 0;
        else active = 0;
        after_done = 1;
      end
    end
  end

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    if (active) pend = 1;
    else active = 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int c = 0;
    while (done_cnt < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("wait_frame_done", done_cnt >= n, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int c = 0;
    while (k < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("wait_strobes", k >= n, 1'b1);
  endtask

  initial begin : main
    int t0;
    int d0;
    int c;
    #1 rst = 1'b1;
    #1;
    check("reset_outputs", {bus.src_en, bus.lcd_wr, bus.lcd_rs, bus.lcd_data, bus.busy, bus.frame_done, bus.err}, 14'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Nominal frame: no busy, 1-cycle source.
    fast = 1;
    @(negedge clk);
    start  = 1'b1;
    active = 1;
    @(negedge clk);
    start = 1'b0;
    check("lat_edge_n", bus.lcd_wr, 1'b0);
    check("busy_after_start", bus.busy, 1'b1);
    @(negedge clk);
    check("lat_edge_n1", bus.lcd_wr, 1'b1);
    check("first_cmd", bus.lcd_data, 8'hB8);
    wait_frames(1, 5000);
    check("full_total", total, 528);
    fast = 0;

    // Backpressure windows.
    bp_mode = 1;
    start_pulse();
    wait_frames(2, 10000);
    bp_mode = 0;
    check("bp_total", total, 1056);

    // Source never answers the 5th request.
    busy_rand = 1;
    req_n = 0;
    drop_n = 5;
    d0 = done_cnt;
    start_pulse();
    c = 0;
    while (!bus.err && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("to_err", bus.err, 1'b1);
    check("to_err_latency", cyc - drop_cyc, WAIT_MAX + 1);
    check("to_busy", bus.busy, 1'b0);
    check("to_strobes", k, 6);
    check("to_no_done", done_cnt, d0);
    active = 0;
    pend = 0;
    k = 0;
    drop_n = -1;
    repeat (3) @(negedge clk);
    check("to_err_sticky", bus.err, 1'b1);
    start_pulse();
    check("err_cleared", bus.err, 1'b0);
    wait_frames(d0 + 1, 10000);

    // Three extra requests during a frame collapse into one follow-on frame.
    d0 = done_cnt;
    t0 = total;
    start_pulse();
    wait_strobes(10, 2000);
    for (int i = 0; i < 3; i++) begin
      start_pulse();
      repeat ($urandom_range(5, 40)) @(negedge clk);
    end
    wait_frames(d0 + 2, 20000);
    check("pend_frames", done_cnt - d0, 2);
    check("pend_total", total - t0, 1056);
    check("pend_idle", bus.busy, 1'b0);

    // Reset after page 4 col 30 is written.
    start_pulse();
    wait_strobes(4 * 66 + 2 + 31, 10000);
    #2 rst = 1'b1;
    #1;
    check("midrst_outputs", {bus.src_en, bus.lcd_wr, bus.lcd_rs, bus.lcd_data, bus.busy, bus.frame_done, bus.err}, 14'd0);
    active = 0;
    pend = 0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    k = 0;
    req_n = 0;
    exp_q.delete();
    t0 = total;
    repeat (20) @(negedge clk);
    check("midrst_no_strobes", total, t0);
    d0 = done_cnt;
    start_pulse();
    wait_frames(d0 + 1, 10000);

    // Stray src_valid in IDLE and in SET_PAGE.
    busy_rand = 0;
    @(negedge clk);
    stray_data  = 8'hEE;
    stray_valid = 1'b1;
    @(negedge clk);
    stray_valid = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    start  = 1'b1;
    active = 1;
    @(posedge clk);
    #1;
    start       = 1'b0;
    stray_data  = 8'h5A;
    stray_valid = 1'b1;
    @(posedge clk);
    #1;
    stray_valid = 1'b0;
    busy_rand   = 1;
    wait_frames(d0 + 1, 10000);
    check("stray_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_frame_sched.md
LCD_FRAME_SCHED -- requirements
Module: lcd_frame_sched

Interface
REQ-001 SHALL provide parameters: CMD_PAGE, default 8'hB8, page-address command base; CMD_COL, default 8'h40, column-address command base; WAIT_MAX, default 8'd16, max cycles from src_en to src_valid.
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port: start  input  1  frame refresh request, sampled each cycle.
REQ-005 SHALL provide port: src_en  output  1  one-cycle request for the next column byte from the frame source.
REQ-006 SHALL provide port: src_data  input  8  column byte from the frame source.
REQ-007 SHALL provide port: src_valid  input  1  src_data qualifier.
REQ-008 SHALL provide port: lcd_busy  input  1  LCD interface cannot accept a write.
REQ-009 SHALL provide port: lcd_wr  output  1  one-cycle write strobe to the LCD.
REQ-010 SHALL provide port: lcd_rs  output  1  0 = command, 1 = data; valid while lcd_wr = 1.
REQ-011 SHALL provide port: lcd_data  output  8  write payload; valid while lcd_wr = 1.
REQ-012 SHALL provide port: busy  output  1  high in every state except IDLE.
REQ-013 SHALL provide port: frame_done  output  1  one-cycle pulse on frame completion.
REQ-014 SHALL provide port: err  output  1  sticky source-timeout flag.
REQ-015 SHALL register all outputs.

Function
REQ-016 SHALL implement the states IDLE, SET_PAGE, SET_COL, FETCH, WAIT_DATA, WRITE and DONE.
REQ-017 SHALL keep a 3-bit page counter (0..7) and a 6-bit column counter (0..63); both clear in IDLE.
REQ-018 IDLE: start = 1 SHALL clear err and move to SET_PAGE next cycle; start = 0 SHALL remain in IDLE.
REQ-019 SET_PAGE: when lcd_busy = 0, SHALL assert lcd_wr for 1 cycle with lcd_rs = 0 and lcd_data = CMD_PAGE | page, then go to SET_COL; while lcd_busy = 1, SHALL hold with lcd_wr = 0.
REQ-020 SET_COL: SHALL behave as SET_PAGE but with lcd_data = CMD_COL (column 0), then go to FETCH.
REQ-021 FETCH: SHALL assert src_en for exactly 1 cycle, load the timeout counter with 0, and go to WAIT_DATA.
REQ-022 WAIT_DATA: on src_valid = 1, SHALL latch src_data and go to WRITE; src_valid in any other state SHALL be ignored.
REQ-023 WAIT_DATA: if the timeout counter reaches WAIT_MAX without src_valid, SHALL set err = 1, drop the frame, and go to IDLE without a frame_done pulse.
REQ-024 WRITE: when lcd_busy = 0, SHALL assert lcd_wr for 1 cycle with lcd_rs = 1 and lcd_data = the latched byte.
REQ-025 After each WRITE, if col < 63, SHALL increment col and go to FETCH.
REQ-026 After a WRITE with col = 63 and page < 7, SHALL clear col, increment page, and go to SET_PAGE.
REQ-027 After a WRITE with col = 63 and page = 7, SHALL go to DONE.
REQ-028 A full frame SHALL consist of exactly 528 lcd_wr strobes: per page, 2 commands followed by 64 data bytes, in page order 0..7.
REQ-029 DONE: SHALL pulse frame_done for 1 cycle, then go to SET_PAGE if pending = 1 (clearing pending), else go to IDLE.
REQ-030 Start handling: start = 1 in any non-IDLE state SHALL set pending; multiple requests SHALL collapse into one; pending SHALL be cleared by a timeout abort.
REQ-031 Latency: with lcd_busy = 0 and start sampled high at edge N, SHALL assert the first lcd_wr after edge N+1.
REQ-032 Latency: with lcd_busy = 0 and src_valid returned 1 cycle after src_en, each data byte SHALL take 3 cycles (FETCH, WAIT_DATA, WRITE).
REQ-033 Counters SHALL never wrap inside a frame; no increment beyond page 7 / col 63 SHALL occur.
REQ-034 lcd_busy rising in the same cycle a write would be issued SHALL suppress that write; the write SHALL be retried, never lost or duplicated.

Reset
REQ-035 While rst = 1, SHALL force (asynchronously) state = IDLE, page = 0, col = 0, pending = 0, timeout counter = 0, data latch = 0.
REQ-036 While rst = 1, SHALL force (asynchronously) all outputs to 0: src_en, lcd_wr, lcd_rs, lcd_data = 8'h00, busy, frame_done, err.
REQ-037 Reset asserted mid-frame SHALL abort the frame with no further strobes; after release, SHALL wait in IDLE for a fresh start.

Verification
REQ-038 Full frame: start pulse, lcd_busy = 0, source returns byte = {page, col[4:0]} 1 cycle after src_en -> 528 strobes, first two B8/40, page 3 header B8+3 = BB then 40, frame_done once, busy falls the cycle after.
REQ-039 Backpressure: hold lcd_busy = 1 for 10 cycles at the SET_COL command and at byte col 17 of page 2 -> no strobe while busy, each write emitted exactly once after release, byte sequence unchanged.
REQ-040 Timeout: source never answers the 5th src_en -> err = 1 after WAIT_MAX cycles, busy = 0, exactly 2+4 strobes seen, no frame_done; the next start clears err.
REQ-041 Pending start: 3 start pulses during a frame -> exactly one extra frame begins right after frame_done (SET_PAGE, page 0), 1056 strobes total.
REQ-042 Reset mid-frame: assert rst at page 4 col 30 -> all outputs 0 immediately; no strobes until start; the next frame begins at B8.
REQ-043 Stray valid: src_valid pulses while in IDLE and in SET_PAGE -> ignored; data stream matches the requested bytes only.
